// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
// Shared RV32I definitions for the instruction encoder.
//   imm_src_t  : ImmSrc format selector (I/S/B/J/U, 101-111 illegal)
//   IMM_*      : ImmSrc format constants
//   enc_req_t  : one encode request {imm_src, imm, opcode, rd, rs1, rs2, funct3}
// ---------------------------------------------------------------------------
package rv32i_pkg;

    typedef logic [2:0] imm_src_t;

    localparam imm_src_t IMM_I = 3'b000;
    localparam imm_src_t IMM_S = 3'b001;
    localparam imm_src_t IMM_B = 3'b010;
    localparam imm_src_t IMM_J = 3'b011;
    localparam imm_src_t IMM_U = 3'b100;

    typedef struct packed {
        imm_src_t    imm_src;
        logic [31:0] imm;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
    } enc_req_t;

endpackage

// File: rtl/imm_range_chk.sv
// ---------------------------------------------------------------------------
// imm_range_chk
// Combinational check: can the given immediate be encoded exactly in the
// selected ImmSrc format?
//   imm_src : ImmSrc format (101-111 always flag an error)
//   imm     : 32-bit signed immediate (byte offset for B and J)
//   err     : 1 when the immediate is not representable or imm_src is illegal
// ---------------------------------------------------------------------------
module imm_range_chk
    import rv32i_pkg::*;
(
    input  logic [2:0]  imm_src,
    input  logic [31:0] imm,
    output logic        err
);

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        err = 1'b0;
        case (imm_src)
            IMM_I, IMM_S: err = (imm != {{20{imm[11]}}, imm[11:0]});
            // Branch and jump offsets are halfword aligned; bit 0 is not stored.
            IMM_B:        err = imm[0] | (imm != {{19{imm[12]}}, imm[12:0]});
            IMM_J:        err = imm[0] | (imm != {{11{imm[20]}}, imm[20:0]});
            // U carries only the upper 20 bits; the low 12 must already be zero.
            IMM_U:        err = |imm[11:0];
            default:      err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_encode.sv
// ---------------------------------------------------------------------------
// imm_encode
// Two-stage valid/ready RV32I instruction encoder (inverse of the immediate
// extender). Stage 1 registers the request; its range check and the packed
// word are captured by the output stage.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : request handshake
//   ImmSrc, imm, opcode,
//   rd, rs1, rs2, funct3: request fields
//   out_valid/out_ready : result handshake
//   instr               : encoded instruction word
//   out_err             : immediate not representable, or ImmSrc illegal
//   stat_enc, stat_err  : saturating output/error counters
// Optional feature: define IMM_ENCODE_STATS_EN to build the statistics
// counters; otherwise stat_enc/stat_err are tied to zero.
// ---------------------------------------------------------------------------
module imm_encode
    import rv32i_pkg::*;
#(
    parameter int PIPE_REGS = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ImmSrc,
    input  logic [31:0]      imm,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr,
    output logic             out_err,
    output logic [CNT_W-1:0] stat_enc,
    output logic [CNT_W-1:0] stat_err
);

    generate
        if (PIPE_REGS != 2) begin : g_depth_check
            $error("imm_encode: only PIPE_REGS == 2 is supported");
        end
    endgenerate

    logic        s1_valid_q;
    enc_req_t    s1_req_q;
    logic        out_valid_q;
    logic [31:0] instr_q;
    logic        out_err_q;

    logic        s1_adv;
    logic [31:0] instr_d;
    logic        err_d;

    // Stage 1 may move forward when the output slot is empty or draining.
    assign s1_adv   = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s1_adv;

    // Valid bits and visible outputs are reset; in-flight entries are dropped.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            out_err_q   <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
            end
            if (s1_adv) begin
                out_valid_q <= s1_valid_q;
                // Data only moves with a valid entry, so a bubble never
                // disturbs the word held on the output.
                if (s1_valid_q) begin
                    instr_q   <= instr_d;
                    out_err_q <= err_d;
                end
            end
        end
    end

    // NOTE: the stage-1 payload has no reset; it is qualified by s1_valid_q
    // and is never observed while that bit is clear.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_req_q <= '{imm_src: ImmSrc, imm: imm, opcode: opcode, rd: rd,
                          rs1: rs1, rs2: rs2, funct3: funct3};
        end
    end

    imm_range_chk u_range_chk (
        .imm_src (s1_req_q.imm_src),
        .imm     (s1_req_q.imm),
        .err     (err_d)
    );

    // Range errors still pack the truncated bits; only an illegal format
    // yields an all-zero word.
    always_comb begin
        instr_d = '0;
        case (s1_req_q.imm_src)
            IMM_I: instr_d = {s1_req_q.imm[11:0], s1_req_q.rs1, s1_req_q.funct3,
                              s1_req_q.rd, s1_req_q.opcode};
            IMM_S: instr_d = {s1_req_q.imm[11:5], s1_req_q.rs2, s1_req_q.rs1,
                              s1_req_q.funct3, s1_req_q.imm[4:0], s1_req_q.opcode};
            IMM_B: instr_d = {s1_req_q.imm[12], s1_req_q.imm[10:5], s1_req_q.rs2,
                              s1_req_q.rs1, s1_req_q.funct3, s1_req_q.imm[4:1],
                              s1_req_q.imm[11], s1_req_q.opcode};
            IMM_J: instr_d = {s1_req_q.imm[20], s1_req_q.imm[10:1], s1_req_q.imm[11],
                              s1_req_q.imm[19:12], s1_req_q.rd, s1_req_q.opcode};
            IMM_U: instr_d = {s1_req_q.imm[31:12], s1_req_q.rd, s1_req_q.opcode};
            default: instr_d = '0;
        endcase
    end

    assign out_valid = out_valid_q;
    assign instr     = instr_q;
    assign out_err   = out_err_q;

`ifdef IMM_ENCODE_STATS_EN
    logic [CNT_W-1:0] stat_enc_q;
    logic [CNT_W-1:0] stat_err_q;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_enc_q <= '0;
            stat_err_q <= '0;
        end else if (out_valid_q && out_ready) begin
            if (!(&stat_enc_q)) begin
                stat_enc_q <= stat_enc_q + 1'b1;
            end
            if (out_err_q && !(&stat_err_q)) begin
                stat_err_q <= stat_err_q + 1'b1;
            end
        end
    end

    assign stat_enc = stat_enc_q;
    assign stat_err = stat_err_q;
`else
    assign stat_enc = '0;
    assign stat_err = '0;
`endif

endmodule

// File: tb/tb_imm_encode.sv
// ---------------------------------------------------------------------------
// tb_imm_encode
// Self-checking bench for imm_encode: directed encodings, latency,
// backpressure, reset while busy, then a randomized stream compared against
// an arithmetic reference model and a round-trip through the core extender.
// ---------------------------------------------------------------------------
module tb_imm_encode;
    import rv32i_pkg::*;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       ImmSrc;
    logic [31:0]      imm;
    logic [6:0]       opcode;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      instr;
    logic             out_err;
    logic [CNT_W-1:0] stat_enc;
    logic [CNT_W-1:0] stat_err;

    imm_encode #(.PIPE_REGS(2), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ImmSrc    (ImmSrc),
        .imm       (imm),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .out_err   (out_err),
        .stat_enc  (stat_enc),
        .stat_err  (stat_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic model_err(input logic [2:0] src, input logic [31:0] value);
        int signed v;
        v = value;
        case (src)
            3'd0, 3'd1: return !(v >= -2048 && v <= 2047);
            3'd2:       return (v % 2 != 0) || !(v >= -4096 && v <= 4095);
            3'd3:       return (v % 2 != 0) || !(v >= -(1 << 20) && v <= (1 << 20) - 1);
            3'd4:       return (v % 4096) != 0;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] model_pack(input logic [2:0] src, input logic [31:0] u,
                                               input logic [6:0] opc, input logic [4:0] d,
                                               input logic [4:0] s1, input logic [4:0] s2,
                                               input logic [2:0] f3);
        logic [31:0] base_r;
        base_r = (32'(s1) << 15) | (32'(f3) << 12) | 32'(opc);
        case (src)
            3'd0: return ((u & 32'hFFF) << 20) | base_r | (32'(d) << 7);
            3'd1: return (((u >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | base_r
                         | ((u & 32'h1F) << 7);
            3'd2: return (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25)
                         | (32'(s2) << 20) | base_r | (((u >> 1) & 32'hF) << 8)
                         | (((u >> 11) & 32'h1) << 7);
            3'd3: return (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                         | (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12)
                         | (32'(d) << 7) | 32'(opc);
            3'd4: return (u & 32'hFFFF_F000) | (32'(d) << 7) | 32'(opc);
            default: return 32'h0;
        endcase
    endfunction

    // The core's immediate extender, used for the round-trip check.
    function automatic logic [31:0] extend(input logic [31:0] i, input logic [2:0] src);
        case (src)
            3'd0: return {{20{i[31]}}, i[31:20]};
            3'd1: return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            3'd4: return {i[31:12], 12'h000};
            default: return 32'h0;
        endcase
    endfunction

    typedef struct {
        logic [2:0]  src;
        logic [31:0] imm;
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          sb_enc = 0;
    int          sb_err = 0;
    bit          held_v = 1'b0;
    logic [31:0] held_instr;
    logic        held_err;

    task automatic drive_req(input logic [2:0] src, input logic [31:0] v, input logic [6:0] opc,
                             input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                             input logic [2:0] f3);
        ImmSrc = src; imm = v; opcode = opc; rd = d; rs1 = s1; rs2 = s2; funct3 = f3;
    endtask

    task automatic drive_rand();
        int signed bnd[12] = '{2047, -2048, 2048, -2049, 4094, -4096, 4096, 4095,
                               1048574, -1048576, 1048576, 0};
        int unsigned r;
        logic [31:0] v;
        r = $urandom_range(0, 11);
        ImmSrc = (r < 10) ? 3'(r % 5) : 3'($urandom_range(5, 7));
        case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = 32'($signed($urandom_range(0, 1 << 22)) - (1 << 21));
            2: v = bnd[$urandom_range(0, 11)];
            default: v = $urandom & 32'hFFFF_F000;
        endcase
        imm = v;
        opcode = 7'($urandom); rd = 5'($urandom); rs1 = 5'($urandom);
        rs2 = 5'($urandom); funct3 = 3'($urandom);
    endtask

    // Called just after a falling edge with inputs driven: samples both
    // handshakes, updates the scoreboard and advances to the next falling edge.
    task automatic tick(output bit acc);
        exp_t e;
        #1;
        if (held_v) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_instr", instr, held_instr);
            check("stall_err", 32'(out_err), 32'(held_err));
        end
        acc = in_valid && in_ready;
        if (acc) begin
            e.src   = ImmSrc;
            e.imm   = imm;
            e.instr = model_pack(ImmSrc, imm, opcode, rd, rs1, rs2, funct3);
            e.err   = model_err(ImmSrc, imm);
            exp_q.push_back(e);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("instr", instr, e.instr);
                check("err", 32'(out_err), 32'(e.err));
                if (!e.err) check("roundtrip", extend(instr, e.src), e.imm);
                sb_enc++;
                if (out_err) sb_err++;
            end
        end
        held_v     = out_valid && !out_ready;
        held_instr = instr;
        held_err   = out_err;
        @(negedge clk);
    endtask

    // One request through an empty pipe with out_ready held high.
    task automatic single(input string tag, input logic [2:0] src, input logic [31:0] v,
                          input logic [6:0] opc, input logic [4:0] d, input logic [4:0] s1,
                          input logic [4:0] s2, input logic [2:0] f3,
                          input logic [31:0] exp_instr, input logic exp_err);
        drive_req(src, v, opc, d, s1, s2, f3);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1 check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        check({tag, "_lat2_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_instr"}, instr, exp_instr);
        check({tag, "_err"}, 32'(out_err), 32'(exp_err));
        sb_enc++;
        if (exp_err) sb_err++;
        @(negedge clk);
        #1 check({tag, "_drained"}, 32'(out_valid), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        bit acc;
        int idx;
        int accepted;
        int cycles;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        drive_req(3'd0, 32'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0);
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_err", 32'(out_err), 32'd0);
        check("rst_stat_enc", 32'(stat_enc), 32'd0);
        check("rst_stat_err", 32'(stat_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed encodings.
        single("addi", IMM_I, 32'hFFFF_FFFF, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 32'hFFF1_0093, 1'b0);
        single("beq_m4", IMM_B, 32'hFFFF_FFFC, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFE00_0EE3, 1'b0);
        single("beq_odd", IMM_B, 32'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0000_0163, 1'b1);
        single("lui", IMM_U, 32'h1234_5000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_52B7, 1'b0);
        single("jal_big", IMM_J, 32'h0010_0000, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 32'h8000_006F, 1'b1);
        single("illegal", 3'b111, 32'h0000_0004, 7'h13, 5'd3, 5'd4, 5'd5, 3'd1, 32'h0000_0000, 1'b1);

        // Backpressure: four requests into a stalled output.
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            drive_req(IMM_I, 32'(idx * 100), 7'h13, 5'(idx + 1), 5'd7, 5'd0, 3'd0);
            in_valid = 1'b1;
            tick(acc);
            check("bp_in_ready", 32'(acc), (c < 2) ? 32'd1 : 32'd0);
            if (acc) idx++;
        end
        out_ready = 1'b1;
        cycles = 0;
        while ((idx < 4 || exp_q.size() != 0) && cycles < 20) begin
            if (idx < 4) begin
                drive_req(IMM_I, 32'(idx * 100), 7'h13, 5'(idx + 1), 5'd7, 5'd0, 3'd0);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick(acc);
            if (acc) idx++;
            cycles++;
        end
        check("bp_drained", 32'(exp_q.size()), 32'd0);
        in_valid = 1'b0;
        repeat (3) tick(acc);

        // Reset with both stages full.
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive_rand();
            in_valid = 1'b1;
            tick(acc);
        end
        check("rst_busy_valid_before", 32'(out_valid), 32'd1);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_busy_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy_stat_enc", 32'(stat_enc), 32'd0);
        exp_q.delete();
        held_v = 1'b0;
        sb_enc = 0;
        sb_err = 0;
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            #1 check("rst_no_stale", 32'(out_valid), 32'd0);
            @(negedge clk);
        end

        // Randomized stream against the reference model.
        accepted = 0;
        cycles   = 0;
        while (accepted < 10000 && cycles < 60000) begin
            drive_rand();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick(acc);
            if (acc) accepted++;
            cycles++;
        end
        check("rand_accepted", 32'(accepted), 32'd10000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 10) begin
            tick(acc);
            cycles++;
        end
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        #1;
`ifdef IMM_ENCODE_STATS_EN
        check("stat_enc", 32'(stat_enc), 32'(sb_enc));
        check("stat_err", 32'(stat_err), 32'(sb_err));
`else
        check("stat_enc_tied", 32'(stat_enc), 32'd0);
        check("stat_err_tied", 32'(stat_err), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_encode.md
Name: imm_encode

Overview:
Instruction/immediate encoder, the inverse of the core's immediate extender. Packs a 32-bit signed immediate and register/function fields into a 32-bit RV32I instruction word for a given ImmSrc format, and flags immediates the format cannot represent. It is a 2-stage valid/ready pipeline used by the debug loader and self-test sequencer to build instructions for instruction memory.

Parameters:
- PIPE_REGS, 2, pipeline depth; only 2 is supported (check stage + output stage).
- CNT_W, 16, width of the statistics counters (used only when the optional feature is enabled).

Ports:
- clk, input, 1, clock; all state changes on the rising edge.
- reset, input, 1, synchronous active-high reset.
- in_valid, input, 1, request valid.
- in_ready, output, 1, request accepted when in_valid && in_ready.
- ImmSrc, input, 3, format: 000 I, 001 S, 010 B, 011 J, 100 U; 101–111 illegal.
- imm, input, 32, signed immediate; byte offset for B and J.
- opcode, input, 7, opcode field.
- rd, input, 5, destination register.
- rs1, input, 5, source register 1.
- rs2, input, 5, source register 2.
- funct3, input, 3, funct3 field.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts when out_valid && out_ready.
- instr, output, 32, encoded instruction.
- out_err, output, 1, immediate not representable, or ImmSrc illegal.
- stat_enc, output, CNT_W, count of encoded instructions (optional feature).
- stat_err, output, CNT_W, count of errored instructions (optional feature).

Behaviour:
- Reset: s1_valid, s2_valid, out_valid, instr, out_err and both counters are cleared to 0. Reset in mid-operation discards in-flight entries with no output.
- Handshake and advance rules:
  - s1_adv = !s2_valid || out_ready.
  - in_ready = !s1_valid || s1_adv; this is combinational and depends on out_ready.
  - Full throughput is 1 request per cycle. Latency is 2 cycles from acceptance to out_valid.
- Output stability: instr and out_err are held stable while out_valid && !out_ready.
- Stage 1 registers the inputs and computes the range check:
  - I and S: err if imm != sign-extend(imm[11:0]).
  - B: err if imm[0] = 1 or imm != sign-extend(imm[12:0]).
  - J: err if imm[0] = 1 or imm != sign-extend(imm[20:0]).
  - U: err if imm[11:0] != 0.
  - ImmSrc 101–111: err = 1.
- Stage 2 packs the word. In every format, bits [6:0] = opcode.
  - I: [31:20] = imm[11:0], [19:15] = rs1, [14:12] = funct3, [11:7] = rd.
  - S: [31:25] = imm[11:5], [24:20] = rs2, [19:15] = rs1, [14:12] = funct3, [11:7] = imm[4:0].
  - B: [31] = imm[12], [30:25] = imm[10:5], [24:20] = rs2, [19:15] = rs1, [14:12] = funct3, [11:8] = imm[4:1], [7] = imm[11].
  - J: [31] = imm[20], [30:21] = imm[10:1], [20] = imm[11], [19:12] = imm[19:12], [11:7] = rd.
  - U: [31:12] = imm[31:12], [11:7] = rd.
  - Illegal ImmSrc: instr = 32'b0.
- Range errors do not zero the word: it is still packed from truncated bits, with out_err = 1.
- Round-trip invariant: when out_err = 0 and ImmSrc is legal, extend(instr[31:7], ImmSrc) == imm.
- Simultaneous accept and drain in the same cycle: the pipeline shifts with no bubble and no loss.

Optional Feature:
- Macro: IMM_ENCODE_STATS_EN.
- With the macro defined:
  - stat_enc increments on every output handshake.
  - stat_err increments on every output handshake with out_err = 1.
  - Both counters saturate at all-ones and clear on reset.
- Without the macro: stat_enc and stat_err are tied to 0 and no counter flops are built.

Decomposition:
- Shared package rv32i_pkg holds:
  - ImmSrc constants IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100;
  - typedef imm_src_t (logic [2:0]);
  - a struct enc_req_t carrying {ImmSrc, imm, opcode, rd, rs1, rs2, funct3}.
- One natural sub-module, imm_range_chk: combinational range check that outputs err for a given ImmSrc and imm.

Test Plan:
- I, ADDI: ImmSrc = 000, imm = -1, opcode = 0x13, rd = 1, rs1 = 2, funct3 = 0, with out_ready held 1 → instr = 0xFFF10093, out_err = 0, out_valid exactly 2 cycles after acceptance.
- B, BEQ: ImmSrc = 010, imm = -4, opcode = 0x63, rs1 = 0, rs2 = 0 → instr = 0xFE000EE3. The same request with imm = 3 → out_err = 1.
- U and J: ImmSrc = 100, imm = 0x12345000, opcode = 0x37, rd = 5 → 0x123452B7. ImmSrc = 011, imm = 0x100000 → out_err = 1.
- Backpressure: stream 4 requests with out_ready = 0 → in_ready falls after 2 accepts. Releasing out_ready drains all 4 in order, with no duplicates and instr stable while stalled.
- Reset during activity: assert reset with both stages full → out_valid = 0 on the next cycle and no stale output appears afterwards. Illegal ImmSrc = 111 → instr = 0, out_err = 1.
- Random round-trip of 10k requests through the reference extend model → decoded immediate equals imm whenever out_err = 0. With IMM_ENCODE_STATS_EN defined, stat_enc and stat_err match the scoreboard counts.
